// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: default geometry and next-PC select encoding
// shared by the fetch-address sequencer and its return stack.
package pc_sequencer_pkg;

  localparam int PC_W_DEF      = 32;
  localparam int STEP_DEF      = 4;
  localparam int RAS_DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    SEQ,
    BR,
    J,
    JR,
    RET
  } npc_sel_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control-flow inputs and fetch-address outputs
// of the sequencer; master drives control, slave is the sequencer.
interface pc_sequencer_if
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
);

  logic            stall;
  logic            br_taken;
  logic [15:0]     br_off;
  logic            jump;
  logic [25:0]     jtarget;
  logic            jr;
  logic [PC_W-1:0] jr_addr;
  logic            jal;
  logic            ret;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] link_addr;
  logic            ras_empty;
  logic            ras_full;

  modport master (
    output stall, br_taken, br_off,
    output jump, jtarget, jr, jr_addr,
    output jal, ret,
    input  pc, link_addr,
    input  ras_empty, ras_full
  );

  modport slave (
    input  stall, br_taken, br_off,
    input  jump, jtarget, jr, jr_addr,
    input  jal, ret,
    output pc, link_addr,
    output ras_empty, ras_full
  );

endinterface

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push when full
// overwrites the oldest entry and the count saturates.
module pc_ras
  import pc_sequencer_pkg::*;
#(
  parameter int W     = PC_W_DEF,
  parameter int DEPTH = RAS_DEPTH_DEF,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  top,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] ptr;
  logic [AW-1:0] wr_idx;
  logic          do_pop;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign do_pop = pop & ~empty;
  assign top    = mem[ptr];

  // pop-then-push reuses the slot just vacated
  always_comb begin
    wr_idx = ptr + AW'(1);
    if (do_pop)
      wr_idx = ptr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      count <= '0;
    end else begin
      unique case ({push, do_pop})
        2'b10: begin
          ptr <= ptr + AW'(1);
          if (!full)
            count <= count + CW'(1);
        end
        2'b01: begin
          ptr   <= ptr - AW'(1);
          count <= count - CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_idx] <= din;
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC with branch/jump/jr redirect and an optional
// return-address stack compiled in by PC_SEQUENCER_RAS_EN.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int RAS_DEPTH = RAS_DEPTH_DEF,
  parameter int STEP      = STEP_DEF
) (
  input logic           clk,
  input logic           rst_n,
  pc_sequencer_if.slave bus
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] link;
  logic [PC_W-1:0] off_ext;
  logic [PC_W-1:0] br_tgt;
  logic [PC_W-1:0] j_tgt;
  logic [PC_W-1:0] ret_tgt;
  logic [PC_W-1:0] npc;
  logic [27:0]     jt28;
  logic            use_ret;
  npc_sel_e        sel;

  assign link    = pc_q + PC_W'(STEP);
  assign off_ext = PC_W'($signed(bus.br_off));
  assign br_tgt  = link + (off_ext << 2);
  assign jt28    = {bus.jtarget, 2'b00};

  generate
    if (PC_W > 28) begin : g_jhi
      assign j_tgt = {link[PC_W-1:28], jt28};
    end else begin : g_jlo
      assign j_tgt = jt28[PC_W-1:0];
    end
  endgenerate

`ifdef PC_SEQUENCER_RAS_EN
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic          push;
  logic          pop;
  logic          r_empty;
  logic          r_full;
  logic [CW-1:0] unused_count;

  assign push = bus.jal & bus.jump & ~bus.stall;
  assign pop  = bus.ret & bus.jr & ~bus.stall;

  pc_ras #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (link),
    .top   (ret_tgt),
    .count (unused_count),
    .empty (r_empty),
    .full  (r_full)
  );

  assign use_ret       = bus.ret & ~r_empty;
  assign bus.ras_empty = r_empty;
  assign bus.ras_full  = r_full;
`else
  logic unused_ras;

  // without the stack, ret degrades to a plain jr
  assign unused_ras    = ^{bus.jal, bus.ret};
  assign ret_tgt       = '0;
  assign use_ret       = 1'b0;
  assign bus.ras_empty = 1'b1;
  assign bus.ras_full  = 1'b0;
`endif

  always_comb begin
    sel = SEQ;
    if (bus.jr)
      sel = use_ret ? RET : JR;
    else if (bus.jump)
      sel = J;
    else if (bus.br_taken)
      sel = BR;
  end

  always_comb begin
    npc = link;
    unique case (sel)
      BR:      npc = br_tgt;
      J:       npc = j_tgt;
      JR:      npc = bus.jr_addr;
      RET:     npc = ret_tgt;
      default: npc = link;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pc_q <= '0;
    else if (!bus.stall)
      pc_q <= npc;
  end

  assign bus.pc        = pc_q;
  assign bus.link_addr = link;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vectors against a queue-based model of the
// sequencer, plus a randomized walk of the stand-alone return stack.
module tb_pc_sequencer;

  localparam int PC_W  = 32;
  localparam int DEPTH = 4;
  localparam int STEP  = 4;
`ifdef PC_SEQUENCER_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  bit   cmp_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pc_sequencer_if #(.PC_W(PC_W)) bus ();

  pc_sequencer #(
    .PC_W      (PC_W),
    .RAS_DEPTH (DEPTH),
    .STEP      (STEP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic        r_push = 1'b0;
  logic        r_pop  = 1'b0;
  logic [11:0] r_din  = '0;
  logic [11:0] r_top;
  logic [2:0]  r_count;
  logic        r_empty;
  logic        r_full;

  pc_ras #(.W(12), .DEPTH(4)) u_ras (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (r_push),
    .pop   (r_pop),
    .din   (r_din),
    .top   (r_top),
    .count (r_count),
    .empty (r_empty),
    .full  (r_full)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference model: stack as a queue, newest entry at the back
  logic [31:0] m_pc = '0;
  logic [31:0] m_link;
  logic [31:0] m_nxt;
  logic [31:0] m_q[$];
  logic [11:0] r_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = '0;
      m_q.delete();
      r_q.delete();
    end else begin
      if (!bus.stall) begin
        m_link = m_pc + STEP;
        if (bus.jr) begin
          if (RAS && bus.ret && m_q.size() > 0) begin
            m_nxt = m_q[$];
            void'(m_q.pop_back());
          end else
            m_nxt = bus.jr_addr;
        end else if (bus.jump)
          m_nxt = (m_link & 32'hF000_0000) | (32'(bus.jtarget) << 2);
        else if (bus.br_taken)
          m_nxt = m_link + 32'($signed(bus.br_off)) * 4;
        else
          m_nxt = m_link;
        if (RAS && bus.jal && bus.jump) begin
          m_q.push_back(m_link);
          if (m_q.size() > DEPTH)
            void'(m_q.pop_front());
        end
        m_pc = m_nxt;
      end
      if (r_pop && r_q.size() > 0)
        void'(r_q.pop_back());
      if (r_push) begin
        r_q.push_back(r_din);
        if (r_q.size() > 4)
          void'(r_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("pc", bus.pc, m_pc);
      check("link_addr", bus.link_addr, m_pc + STEP);
      check("ras_empty", bus.ras_empty, m_q.size() == 0);
      check("ras_full", bus.ras_full, m_q.size() == DEPTH);
      check("r_count", r_count, r_q.size());
      check("r_empty", r_empty, r_q.size() == 0);
      check("r_full", r_full, r_q.size() == 4);
      if (r_q.size() > 0)
        check("r_top", r_top, r_q[$]);
    end
  end

  task automatic idle();
    bus.stall    = 1'b0;
    bus.br_taken = 1'b0;
    bus.br_off   = '0;
    bus.jump     = 1'b0;
    bus.jtarget  = '0;
    bus.jr       = 1'b0;
    bus.jr_addr  = '0;
    bus.jal      = 1'b0;
    bus.ret      = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_jr(logic [31:0] a);
    bus.jr      = 1'b1;
    bus.jr_addr = a;
    tick();
    idle();
  endtask

  logic [25:0] jts  [5] = '{26'h7, 26'hB, 26'hF, 26'h13, 26'h400};
  logic [31:0] pops [4] = '{32'h50, 32'h40, 32'h30, 32'h20};

  initial begin
    idle();
    #1 rst_n = 1'b0;
    #2;
    check("rst_pc", bus.pc, 32'h0);
    check("rst_empty", bus.ras_empty, 1'b1);
    check("rst_full", bus.ras_full, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cmp_en = 1'b1;
    check("seq0", bus.pc, 32'h0);
    tick(); check("seq4", bus.pc, 32'h4);
    tick(); check("seq8", bus.pc, 32'h8);
    tick(); check("seq12", bus.pc, 32'hC);
    check("link16", bus.link_addr, 32'h10);

    go_jr(32'h100);
    check("jr_100", bus.pc, 32'h100);
    bus.br_taken = 1'b1; bus.br_off = 16'hFFFE;
    tick(); idle();
    check("br_back", bus.pc, 32'hFC);
    go_jr(32'h100);
    bus.br_taken = 1'b1; bus.br_off = 16'hFFFE;
    bus.jump = 1'b1; bus.jtarget = 26'h5;
    bus.jr = 1'b1; bus.jr_addr = 32'h400;
    tick(); idle();
    check("prio_jr", bus.pc, 32'h400);

    go_jr(32'h1000_0010);
    bus.jump = 1'b1; bus.jtarget = 26'h40; bus.jal = 1'b1;
    tick(); idle();
    check("jal_pc", bus.pc, 32'h1000_0100);
    check("jal_empty", bus.ras_empty, !RAS);
    bus.jr = 1'b1; bus.ret = 1'b1; bus.jr_addr = 32'h20;
    tick(); idle();
    check("ret_top", bus.pc, RAS ? 32'h1000_0014 : 32'h20);
    check("ret_empty", bus.ras_empty, 1'b1);

    go_jr(32'hC);
    for (int i = 0; i < 5; i++) begin
      bus.jump = 1'b1; bus.jal = 1'b1; bus.jtarget = jts[i];
      tick(); idle();
    end
    check("push5_pc", bus.pc, 32'h1000);
    check("push5_full", bus.ras_full, RAS);
    for (int i = 0; i < 4; i++) begin
      bus.jr = 1'b1; bus.ret = 1'b1; bus.jr_addr = 32'h99C;
      tick(); idle();
      check("pop_pc", bus.pc, RAS ? pops[i] : 32'h99C);
    end
    bus.jr = 1'b1; bus.ret = 1'b1; bus.jr_addr = 32'h99C;
    tick(); idle();
    check("pop_under", bus.pc, 32'h99C);
    check("pop_empty", bus.ras_empty, 1'b1);

    bus.jump = 1'b1; bus.jal = 1'b1; bus.jtarget = 26'h100;
    tick(); idle();
    check("sim_push", bus.pc, 32'h400);
    bus.jump = 1'b1; bus.jal = 1'b1; bus.jtarget = 26'h100;
    bus.jr = 1'b1; bus.ret = 1'b1; bus.jr_addr = 32'h777;
    tick(); idle();
    check("sim_both", bus.pc, RAS ? 32'h9A0 : 32'h777);
    check("sim_cnt", bus.ras_empty, !RAS);
    bus.jr = 1'b1; bus.ret = 1'b1; bus.jr_addr = 32'h888;
    tick(); idle();
    check("sim_ret", bus.pc, RAS ? 32'h404 : 32'h888);

    bus.jump = 1'b1; bus.jal = 1'b1; bus.jtarget = 26'h200;
    tick(); idle();
    check("pre_stall", bus.pc, 32'h800);
    bus.stall = 1'b1; bus.jump = 1'b1; bus.jal = 1'b1;
    bus.jtarget = 26'h300;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", bus.pc, 32'h800);
      check("stall_cnt", bus.ras_empty, !RAS);
    end
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_pc", bus.pc, 32'h0);
    check("rst_async_empty", bus.ras_empty, 1'b1);
    tick();
    check("rst_hold", bus.pc, 32'h0);
    idle();
    rst_n = 1'b1;
    tick();
    check("rst_first", bus.pc, 32'h4);

    go_jr(32'hFFFF_FFFC);
    check("top_pc", bus.pc, 32'hFFFF_FFFC);
    tick();
    check("wrap", bus.pc, 32'h0);
    bus.br_taken = 1'b1; bus.br_off = 16'h0010;
    tick(); idle();
    check("br_fwd", bus.pc, 32'h44);

    for (int i = 0; i < 300; i++) begin
      r_push = (i < 150) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 2) == 0);
      r_pop  = (i < 150) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
      r_din  = 12'($urandom);
      tick();
    end
    r_push = 1'b0;
    r_pop  = 1'b0;
    tick();
    tick();
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
